debug_run_ctrl: RTL and testbench
=================================

# debug_run_ctrl

Run-control sequencer for the RISC-V core's debug path. It decodes host halt, resume and step commands, decoded from the debug Avalon slave's control register, plus an optional PC breakpoint. From these it drives the pipeline-stage enables, the PC enable and the `debug` flag. It drains in-flight instructions before reporting HALTED and notifies the host with a one-cycle `tx_flag` pulse.

## Interface
- `STAGES`, default 4: pipeline stages; sets the `enable_ext` width. Bit 0 is fetch, bit STAGES-1 is write-back.
- `CNT_W`, default 8: width of the step counter.
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: host command present.
- `cmd_op` in 2: command opcode. 00 NOP, 01 HALT, 10 RESUME, 11 STEP.
- `cmd_count` in CNT_W: instruction count for STEP.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `pc` in 32: current fetch PC from the core.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint address.
- `debug` out 1: high while HALTED.
- `enable_ext` out STAGES: per-stage clock enable.
- `enable_pc_ext` out 1: PC register enable.
- `tx_flag` out 1: one-cycle pulse on entry to HALTED.
- `status` out 32: [1:0] state, [3:2] halt reason, [15:8] steps remaining, other bits 0.

## Operation
- States:
  - RUN=0: all enables 1.
  - DRAIN=1: PC frozen, fetch off, later stages on.
  - HALTED=2: all enables 0, `debug`=1.
  - STEP=3: all enables 1.
- Halt reason codes: 0 none, 1 host, 2 breakpoint, 3 step-done.
- `cmd_ready`=1 in RUN and HALTED, 0 in DRAIN and STEP.
- RUN:
  - Accepted HALT -> DRAIN, reason=1.
  - Breakpoint match (`bp_en && pc==bp_addr && !bp_skip`) -> DRAIN, reason=2.
  - If both occur in the same cycle, the breakpoint wins (reason=2).
  - RESUME, STEP and NOP are accepted with no effect.
- DRAIN:
  - `enable_pc_ext`=0, `enable_ext`={STAGES-1 ones, 0}.
  - Drain counter loads STAGES-1 on entry. The state lasts exactly STAGES-1 cycles, then -> HALTED.
- HALTED:
  - Accepted RESUME -> RUN and sets `bp_skip`.
  - Accepted STEP -> STEP. The step counter loads `cmd_count`; a count of 0 is treated as 1. Also sets `bp_skip`.
  - HALT and NOP are accepted and ignored.
- STEP:
  - Enables are high and the counter decrements every cycle.
  - When the counter reaches 0 -> DRAIN, reason=3.
  - Breakpoints are ignored during STEP.
- `bp_skip` clears on the first cycle `pc != bp_addr`, so resuming from a breakpoint PC does not re-halt immediately.
- Reason holds its value until the next halt; it is cleared on RESUME. Steps remaining equals the live step counter.

## Timing
- All outputs are registered and update on the edge after the triggering event.
- Reset values: state RUN, `debug`=0, `enable_ext`=all 1, `enable_pc_ext`=1, `tx_flag`=0, `cmd_ready`=1, `status`=0, counters 0, `bp_skip`=0.
- Halt latency: command accepted at edge N. DRAIN occupies N+1..N+STAGES-1. HALTED and `tx_flag` are at N+STAGES.
- Step of k instructions: STEP occupies k cycles, then DRAIN for STAGES-1, then HALTED with a `tx_flag` pulse.
- `tx_flag` lasts exactly one cycle per HALTED entry and never asserts in any other state.
- Reset mid-operation returns to RUN immediately. Counters are discarded and no `tx_flag` is issued.

## Configuration
- `DEBUG_BREAKPOINT_EN` defined: the comparator and `bp_skip` logic are compiled in.
- `DEBUG_BREAKPOINT_EN` undefined: `bp_en`, `bp_addr` and `pc` are ignored, and reason 2 never occurs.

## Structure
- `debug_pkg` holds:
  - the state enum and reason enum;
  - the opcode constants (OP_NOP, OP_HALT, OP_RESUME, OP_STEP);
  - the `status` field bit positions.
- Sub-module `debug_bp_match` holds the comparator plus the `bp_skip` register and outputs `bp_hit`. It is instantiated only under `DEBUG_BREAKPOINT_EN`.

## Test plan
- Reset, then HALT (op 01) in RUN -> 3 DRAIN cycles with `enable_ext`=1110 and `enable_pc_ext`=0. Then `debug`=1, `enable_ext`=0000, a single `tx_flag` pulse, and `status`[3:0]=0x6.
- From HALTED, STEP with `cmd_count`=5 -> exactly 5 cycles with `enable_ext`=1111, then 3 DRAIN cycles, then HALTED with reason=3. `cmd_ready`=0 throughout.
- From HALTED, STEP with `cmd_count`=0 -> 1 STEP cycle, then DRAIN, then HALTED.
- `bp_en`=1, `bp_addr`=0x100, `pc` reaches 0x100 in the same cycle a HALT is accepted -> reason=2.
- RESUME at `pc`=0x100 -> no re-halt. A later return of `pc` to 0x100 halts again.
- Assert `RST` in the second DRAIN cycle -> next cycle in RUN, all enables 1, no `tx_flag`. Without `DEBUG_BREAKPOINT_EN`, `pc`==`bp_addr` causes no halt.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug run-control block: FSM states,
// halt reasons, host command opcodes and status register field positions.
package debug_pkg;

   typedef enum logic [1:0] {
      STATE_RUN    = 2'd0,
      STATE_DRAIN  = 2'd1,
      STATE_HALTED = 2'd2,
      STATE_STEP   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RSN_NONE = 2'd0,
      RSN_HOST = 2'd1,
      RSN_BP   = 2'd2,
      RSN_STEP = 2'd3
   } reason_e;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_HALT   = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_STEP   = 2'b11;

   localparam int unsigned ST_STATE_LSB  = 32'd0;
   localparam int unsigned ST_REASON_LSB = 32'd2;
   localparam int unsigned ST_STEPS_LSB  = 32'd8;
   localparam int unsigned ST_STEPS_W    = 32'd8;

endpackage

// File: rtl/debug_bp_match.sv
// PC breakpoint comparator with a skip flag that masks the breakpoint address
// until the PC has moved off it once after a resume or step.
module debug_bp_match
   import debug_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] pc,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic        skip_set,
   output logic        bp_hit
);

   logic addr_eq_s;
   logic bp_skip_r;

   assign addr_eq_s = (pc == bp_addr);

   // Skip flag: armed on resume/step, dropped on the first cycle away from bp_addr.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bp_skip_r <= 1'b0;
      end else if (skip_set) begin
         bp_skip_r <= 1'b1;
      end else if (!addr_eq_s) begin
         bp_skip_r <= 1'b0;
      end else begin
         bp_skip_r <= bp_skip_r;
      end
   end

   assign bp_hit = bp_en && addr_eq_s && !bp_skip_r;

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run-control sequencer: halt/resume/step with pipeline drain.
// Optional PC breakpoint compiled in with DEBUG_BREAKPOINT_EN.
module debug_run_ctrl
   import debug_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int CNT_W  = 8
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              cmd_ready,
   input  logic [31:0]       pc,
   input  logic              bp_en,
   input  logic [31:0]       bp_addr,
   output logic              debug,
   output logic [STAGES-1:0] enable_ext,
   output logic              enable_pc_ext,
   output logic              tx_flag,
   output logic [31:0]       status
);

   localparam logic [1:0] RUN    = STATE_RUN;
   localparam logic [1:0] DRAIN  = STATE_DRAIN;
   localparam logic [1:0] HALTED = STATE_HALTED;
   localparam logic [1:0] STEP   = STATE_STEP;

   localparam int DRAIN_W = $clog2(STAGES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(STAGES - 1);

   logic [1:0]         state_r, state_s;
   logic [1:0]         reason_r, reason_s;
   logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_s;
   logic [CNT_W-1:0]   step_cnt_r, step_cnt_s;
   logic               accept_s;
   logic               skip_set_s;
   logic               bp_hit_s;

   logic [STAGES-1:0]  enable_r, enable_s;
   logic               pc_en_r, pc_en_s;
   logic               debug_r, debug_s;
   logic               tx_flag_r, tx_flag_s;
   logic               cmd_ready_r, cmd_ready_s;
   logic [31:0]        status_r, status_s;

   assign accept_s = cmd_valid && cmd_ready_r;

`ifdef DEBUG_BREAKPOINT_EN
   debug_bp_match u_bp_match (
      .CLK      (CLK),
      .RST      (RST),
      .pc       (pc),
      .bp_en    (bp_en),
      .bp_addr  (bp_addr),
      .skip_set (skip_set_s),
      .bp_hit   (bp_hit_s)
   );
`else
   logic unused_bp_s;
   assign unused_bp_s = ^{pc, bp_en, bp_addr, skip_set_s};
   assign bp_hit_s    = 1'b0;
`endif

   // Next-state, halt reason and counter logic.
   always_comb begin
      state_s     = state_r;
      reason_s    = reason_r;
      drain_cnt_s = drain_cnt_r;
      step_cnt_s  = step_cnt_r;
      skip_set_s  = 1'b0;
      case (state_r)
         RUN: begin
            // Breakpoint outranks a host HALT in the same cycle.
            if (bp_hit_s) begin
               state_s     = DRAIN;
               reason_s    = RSN_BP;
               drain_cnt_s = DRAIN_LOAD;
            end else if (accept_s && (cmd_op == OP_HALT)) begin
               state_s     = DRAIN;
               reason_s    = RSN_HOST;
               drain_cnt_s = DRAIN_LOAD;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            if (drain_cnt_r <= DRAIN_W'(1)) begin
               state_s     = HALTED;
               drain_cnt_s = '0;
            end else begin
               drain_cnt_s = drain_cnt_r - DRAIN_W'(1);
            end
         end
         HALTED: begin
            if (accept_s && (cmd_op == OP_RESUME)) begin
               state_s    = RUN;
               reason_s   = RSN_NONE;
               skip_set_s = 1'b1;
            end else if (accept_s && (cmd_op == OP_STEP)) begin
               state_s    = STEP;
               step_cnt_s = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
               skip_set_s = 1'b1;
            end else begin
               state_s = HALTED;
            end
         end
         STEP: begin
            if (step_cnt_r <= CNT_W'(1)) begin
               step_cnt_s  = '0;
               state_s     = DRAIN;
               reason_s    = RSN_STEP;
               drain_cnt_s = DRAIN_LOAD;
            end else begin
               step_cnt_s = step_cnt_r - CNT_W'(1);
            end
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // Output values derived from the upcoming state so they register in step with it.
   always_comb begin
      enable_s    = {STAGES{1'b1}};
      pc_en_s     = 1'b1;
      debug_s     = 1'b0;
      cmd_ready_s = 1'b1;
      case (state_s)
         RUN: begin
            cmd_ready_s = 1'b1;
         end
         DRAIN: begin
            enable_s[0] = 1'b0;
            pc_en_s     = 1'b0;
            cmd_ready_s = 1'b0;
         end
         HALTED: begin
            enable_s = '0;
            pc_en_s  = 1'b0;
            debug_s  = 1'b1;
         end
         STEP: begin
            cmd_ready_s = 1'b0;
         end
         default: begin
            cmd_ready_s = 1'b1;
         end
      endcase
      tx_flag_s = (state_s == HALTED) && (state_r != HALTED);
   end

   // Status word assembly.
   always_comb begin
      status_s = 32'h0000_0000;
      status_s[ST_STATE_LSB  +: 2]          = state_s;
      status_s[ST_REASON_LSB +: 2]          = reason_s;
      status_s[ST_STEPS_LSB  +: ST_STEPS_W] = ST_STEPS_W'(step_cnt_s);
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= RUN;
         reason_r    <= RSN_NONE;
         drain_cnt_r <= '0;
         step_cnt_r  <= '0;
         enable_r    <= {STAGES{1'b1}};
         pc_en_r     <= 1'b1;
         debug_r     <= 1'b0;
         tx_flag_r   <= 1'b0;
         cmd_ready_r <= 1'b1;
         status_r    <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         reason_r    <= reason_s;
         drain_cnt_r <= drain_cnt_s;
         step_cnt_r  <= step_cnt_s;
         enable_r    <= enable_s;
         pc_en_r     <= pc_en_s;
         debug_r     <= debug_s;
         tx_flag_r   <= tx_flag_s;
         cmd_ready_r <= cmd_ready_s;
         status_r    <= status_s;
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign debug         = debug_r;
   assign enable_ext    = enable_r;
   assign enable_pc_ext = pc_en_r;
   assign tx_flag       = tx_flag_r;
   assign status        = status_r;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl (STAGES=4, CNT_W=8); breakpoint
// expectations follow DEBUG_BREAKPOINT_EN.
module tb_debug_run_ctrl;

   logic        CLK;
   logic        RST;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_count;
   logic        cmd_ready;
   logic [31:0] pc;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic        debug;
   logic [3:0]  enable_ext;
   logic        enable_pc_ext;
   logic        tx_flag;
   logic [31:0] status;

   int vectors;
   int miscompares;

`ifdef DEBUG_BREAKPOINT_EN
   localparam int BP_RSN = 2;
`else
   localparam int BP_RSN = 1;
`endif

   debug_run_ctrl #(.STAGES(4), .CNT_W(8)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .cmd_valid     (cmd_valid),
      .cmd_op        (cmd_op),
      .cmd_count     (cmd_count),
      .cmd_ready     (cmd_ready),
      .pc            (pc),
      .bp_en         (bp_en),
      .bp_addr       (bp_addr),
      .debug         (debug),
      .enable_ext    (enable_ext),
      .enable_pc_ext (enable_pc_ext),
      .tx_flag       (tx_flag),
      .status        (status)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] stat(input int st, input int rsn, input int steps);
      return {16'h0000, 8'(steps), 4'h0, 2'(rsn), 2'(st)};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [31:0] st, input logic [3:0] en,
                             input logic pcen, input logic dbg, input logic tx, input logic rdy);
      chk({tag, ".status"}, status, st);
      chk({tag, ".enable_ext"}, 32'(enable_ext), 32'(en));
      chk({tag, ".enable_pc_ext"}, 32'(enable_pc_ext), 32'(pcen));
      chk({tag, ".debug"}, 32'(debug), 32'(dbg));
      chk({tag, ".tx_flag"}, 32'(tx_flag), 32'(tx));
      chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy));
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = cnt;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_count = 8'd0;
      pc        = 32'h0;
      bp_en     = 1'b0;
      bp_addr   = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      expect_out("reset", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      RST = 1'b0;
      tick();
      expect_out("run_idle", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);

      // Host halt: three drain cycles then HALTED with one tx_flag pulse
      send(2'b01, 8'd0);
      for (int i = 0; i < 3; i++) begin
         expect_out("halt_drain", stat(1, 1, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      expect_out("halt_halted", stat(2, 1, 0), 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      expect_out("halt_hold", stat(2, 1, 0), 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Step of 5
      send(2'b11, 8'd5);
      for (int i = 0; i < 5; i++) begin
         expect_out("step5_step", stat(3, 1, 5 - i), 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         expect_out("step5_drain", stat(1, 3, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      expect_out("step5_halted", stat(2, 3, 0), 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Step with count 0 behaves as a single step
      send(2'b11, 8'd0);
      expect_out("step0_step", stat(3, 3, 1), 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_out("step0_drain", stat(1, 3, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      expect_out("step0_halted", stat(2, 3, 0), 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);

      // HALT while halted is ignored; RESUME clears reason
      send(2'b01, 8'd0);
      expect_out("halted_halt_ign", stat(2, 3, 0), 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      send(2'b10, 8'd0);
      expect_out("resume_run", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      send(2'b11, 8'd3);
      expect_out("run_step_ign", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);

      // Breakpoint coincides with host HALT
      bp_en   = 1'b1;
      bp_addr = 32'h100;
      pc      = 32'hFC;
      tick();
      expect_out("bp_approach", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      pc = 32'h100;
      send(2'b01, 8'd0);
      for (int i = 0; i < 3; i++) begin
         expect_out("bp_drain", stat(1, BP_RSN, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      expect_out("bp_halted", stat(2, BP_RSN, 0), 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Resume on the breakpoint PC must not re-halt
      send(2'b10, 8'd0);
      expect_out("bp_resume", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      expect_out("bp_skip_hold", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      pc = 32'h104;
      tick();
      expect_out("bp_moved", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      pc = 32'h100;
      tick();
`ifdef DEBUG_BREAKPOINT_EN
      expect_out("bp_rehit", stat(1, 2, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
`else
      expect_out("bp_ignored", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      send(2'b01, 8'd0);
      expect_out("nobp_drain", stat(1, 1, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      tick();
      expect_out("drain2", stat(1, BP_RSN, 0), 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the second drain cycle
      bp_en = 1'b0;
      RST   = 1'b1;
      #1;
      expect_out("rst_mid", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("rst_after", stat(0, 0, 0), 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
